// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the control/status link.
// Provides bus-width typedefs, the response code enum, the packed write-request
// payload, and a byte-strobe merge helper used by register storage.
package axi_lite_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  // Write request assembled from independently captured AW and W beats
  typedef struct packed {
    addr_t addr;
    data_t data;
    strb_t strb;
  } wr_req_t;

  // Byte lanes with strb=1 take new_val, the rest keep old_val
  function automatic data_t apply_strb(data_t old_val, data_t new_val, strb_t strb);
    data_t res;
    res = old_val;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// NUM_REGS x 32-bit register storage with one byte-strobed write port and one
// combinational read port.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset; every register loads RESET_VAL
//   we       write enable for widx
//   widx     write register index
//   wdata    write data
//   wstrb    write byte enables
//   ridx     read register index
//   rdata_c  combinational read data for ridx (pre-write value on a write edge)
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 16,
  parameter data_t       RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] widx,
  input  data_t                       wdata,
  input  strb_t                       wstrb,
  input  logic [$clog2(NUM_REGS)-1:0] ridx,
  output data_t                       rdata_c
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  data_t regs_q [NUM_REGS];

  // Storage update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[IDX_W'(i)] <= RESET_VAL;
      end
    end else if (we) begin
      regs_q[widx] <= apply_strb(regs_q[widx], wdata, wstrb);
    end
  end

  // NUM_REGS is a power of two, so every index value is a valid entry
  assign rdata_c = regs_q[ridx];

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder fronting NUM_REGS 32-bit read/write registers.
// Independent read (AR/R) and write (AW/W/B) FSMs; accesses at or beyond
// NUM_REGS*4 get SLVERR, return zero data and modify nothing.
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   araddr/arvalid/arready        read address channel
//   rdata/rresp/rvalid/rready     read data channel
//   awaddr/awvalid/awready        write address channel
//   wdata/wstrb/wvalid/wready     write data channel
//   bresp/bvalid/bready           write response channel
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 16,
  parameter data_t       RESET_VAL = '0
) (
  input  logic  aclk,
  input  logic  areset,
  input  addr_t araddr,
  input  logic  arvalid,
  output logic  arready,
  output data_t rdata,
  output resp_t rresp,
  output logic  rvalid,
  input  logic  rready,
  input  addr_t awaddr,
  input  logic  awvalid,
  output logic  awready,
  input  data_t wdata,
  input  strb_t wstrb,
  input  logic  wvalid,
  output logic  wready,
  output resp_t bresp,
  output logic  bvalid,
  input  logic  bready
);

  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned HI_LSB = 2 + IDX_W;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;

  // Address is inside the decoded window when all bits above the index are zero
  function automatic logic in_range(addr_t a);
    return a[ADDR_W-1:HI_LSB] == '0;
  endfunction

  r_state_t          r_state;
  w_state_t          w_state;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_hit;
  data_t             rd_word;

  logic              aw_held;
  logic              w_held;
  wr_req_t           wr_req_q;
  wr_req_t           wr_req;
  logic              aw_fire;
  logic              w_fire;
  logic              commit;
  logic              bank_we;
  logic [IDX_W-1:0]  wr_idx;

  // Byte-offset bits never take part in decode
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{araddr[1:0], wr_req.addr[1:0]};

  // Read decode straight off the AR channel
  assign rd_idx = araddr[2 +: IDX_W];
  assign rd_hit = in_range(araddr);

  // Write request: live channel values on their handshake edge, held copies otherwise
  always_comb begin
    aw_fire     = awvalid && awready;
    w_fire      = wvalid && wready;
    wr_req      = wr_req_q;
    if (aw_fire) wr_req.addr = awaddr;
    if (w_fire) begin
      wr_req.data = wdata;
      wr_req.strb = wstrb;
    end
    commit  = (w_state == W_IDLE) && (aw_fire || aw_held) && (w_fire || w_held);
    bank_we = commit && in_range(wr_req.addr);
    wr_idx  = wr_req.addr[2 +: IDX_W];
  end

  axi_lite_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk     (aclk),
    .rst     (areset),
    .we      (bank_we),
    .widx    (wr_idx),
    .wdata   (wr_req.data),
    .wstrb   (wr_req.strb),
    .ridx    (rd_idx),
    .rdata_c (rd_word)
  );

  // Read FSM: latch data on AR handshake, hold R until accepted
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            r_state <= R_DATA;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= rd_hit ? rd_word : '0;
            rresp   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            r_state <= R_IDLE;
            rvalid  <= 1'b0;
            arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: collect AW and W in any order, commit once both are present
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state  <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      wr_req_q <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (commit) begin
            w_state <= W_RESP;
            bvalid  <= 1'b1;
            bresp   <= in_range(wr_req.addr) ? RESP_OKAY : RESP_SLVERR;
            awready <= 1'b0;
            wready  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end else begin
            // Each channel stalls after its beat until the other one arrives
            if (aw_fire) begin
              aw_held       <= 1'b1;
              wr_req_q.addr <= awaddr;
              awready       <= 1'b0;
            end else begin
              awready <= ~aw_held;
            end
            if (w_fire) begin
              w_held        <= 1'b1;
              wr_req_q.data <= wdata;
              wr_req_q.strb <= wstrb;
              wready        <= 1'b0;
            end else begin
              wready <= ~w_held;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: expected R/B responses are
// queued from a register model when a transaction is issued and compared when
// the DUT hands the response over.
module tb_axi_lite_slave_regs;
  import axi_lite_pkg::*;

  localparam int unsigned NUM_REGS = 16;

  logic  aclk = 1'b0;
  logic  areset;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;
  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;

  always #5 aclk = ~aclk;

  axi_lite_slave_regs #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL ('0)
  ) dut (
    .aclk    (aclk),
    .areset  (areset),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  typedef struct {
    data_t data;
    resp_t resp;
  } exp_t;

  exp_t  rq[$];
  exp_t  bq[$];
  data_t model [NUM_REGS];
  int    n_cmp = 0;
  int    n_err = 0;
  int    r_cnt = 0;
  int    b_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic bit ready_ok(input int which);
    case (which)
      0:       return arready;
      1:       return awready;
      2:       return wready;
      default: return awready && wready;
    endcase
  endfunction

  // Wait (bounded) for the selected ready, then step past the handshake edge
  task automatic wait_ready(input int which, input string tag);
    int k = 0;
    @(negedge aclk);
    while (!ready_ok(which) && k < 20) begin
      @(negedge aclk);
      k++;
    end
    check_eq(tag, 32'(ready_ok(which)), 32'(1));
    tick();
  endtask

  // Response monitor: pops the scoreboard on every R/B handshake
  always @(negedge aclk) begin : mon
    exp_t e;
    if (!areset && rvalid && rready) begin
      check_eq("r_pending", 32'(rq.size() > 0), 32'(1));
      if (rq.size() > 0) begin
        e = rq.pop_front();
        check_eq("rdata", rdata, e.data);
        check_eq("rresp", 32'(rresp), 32'(e.resp));
      end
      r_cnt++;
    end
    if (!areset && bvalid && bready) begin
      check_eq("b_pending", 32'(bq.size() > 0), 32'(1));
      if (bq.size() > 0) begin
        e = bq.pop_front();
        check_eq("bresp", 32'(bresp), 32'(e.resp));
      end
      b_cnt++;
    end
  end

  // lag: cycles W trails AW (0 = same cycle); stall: cycles bready is held low
  task automatic axi_write(input addr_t a, input data_t d, input strb_t s,
                           input int lag, input int stall);
    exp_t e;
    int   k;
    int   b0;
    int   idx;
    bit   hit;
    hit = (a < NUM_REGS * 4);
    idx = int'((a >> 2) & (NUM_REGS - 1));
    if (hit) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
      end
    end
    e.data = '0;
    e.resp = hit ? RESP_OKAY : RESP_SLVERR;
    bq.push_back(e);

    awaddr  = a;
    awvalid = 1'b1;
    if (lag == 0) begin
      wdata  = d;
      wstrb  = s;
      wvalid = 1'b1;
    end
    wait_ready((lag == 0) ? 3 : 1, "aw_ready");
    awvalid = 1'b0;
    if (lag == 0) begin
      wvalid = 1'b0;
    end else begin
      for (int i = 0; i < lag; i++) begin
        @(negedge aclk);
        check_eq("aw_held_off", 32'(awready), 32'(0));
        check_eq("b_early", 32'(bvalid), 32'(0));
        tick();
      end
      wdata  = d;
      wstrb  = s;
      wvalid = 1'b1;
      wait_ready(2, "w_ready");
      wvalid = 1'b0;
    end

    b0    = b_cnt;
    bready = (stall == 0);
    @(negedge aclk);
    check_eq("b_latency", 32'(bvalid), 32'(1));
    for (int i = 0; i < stall; i++) begin
      tick();
      @(negedge aclk);
      check_eq("b_stall_valid", 32'(bvalid), 32'(1));
      check_eq("b_stall_resp", 32'(bresp), 32'(e.resp));
      check_eq("b_stall_aw", 32'(awready), 32'(0));
    end
    if (stall > 0) begin
      tick();
      bready = 1'b1;
    end
    k = 0;
    do begin
      tick();
      k++;
    end while (b_cnt == b0 && k < 10);
    check_eq("b_handshake", 32'(b_cnt - b0), 32'(1));
    bready = 1'b0;
    @(negedge aclk);
    check_eq("b_single", 32'(bvalid), 32'(0));
    tick();
  endtask

  // stall: cycles rready is held low after rvalid rises
  task automatic axi_read(input addr_t a, input int stall);
    exp_t e;
    int   k;
    int   r0;
    bit   hit;
    hit    = (a < NUM_REGS * 4);
    e.data = hit ? model[int'((a >> 2) & (NUM_REGS - 1))] : '0;
    e.resp = hit ? RESP_OKAY : RESP_SLVERR;
    rq.push_back(e);

    araddr  = a;
    arvalid = 1'b1;
    wait_ready(0, "ar_ready");
    arvalid = 1'b0;

    r0     = r_cnt;
    rready = (stall == 0);
    @(negedge aclk);
    check_eq("r_latency", 32'(rvalid), 32'(1));
    for (int i = 0; i < stall; i++) begin
      tick();
      @(negedge aclk);
      check_eq("r_stall_valid", 32'(rvalid), 32'(1));
      check_eq("r_stall_data", rdata, e.data);
      check_eq("r_stall_ar", 32'(arready), 32'(0));
    end
    if (stall > 0) begin
      tick();
      rready = 1'b1;
    end
    k = 0;
    do begin
      tick();
      k++;
    end while (r_cnt == r0 && k < 10);
    check_eq("r_handshake", 32'(r_cnt - r0), 32'(1));
    rready = 1'b0;
  endtask

  task automatic check_all_idle_zero(input string tag);
    check_eq({tag, "_arready"}, 32'(arready), 32'(0));
    check_eq({tag, "_awready"}, 32'(awready), 32'(0));
    check_eq({tag, "_wready"},  32'(wready),  32'(0));
    check_eq({tag, "_rvalid"},  32'(rvalid),  32'(0));
    check_eq({tag, "_bvalid"},  32'(bvalid),  32'(0));
    check_eq({tag, "_rdata"},   rdata,        32'(0));
    check_eq({tag, "_rresp"},   32'(rresp),   32'(0));
    check_eq({tag, "_bresp"},   32'(bresp),   32'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    areset  = 1'b1;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    repeat (3) tick();
    @(negedge aclk);
    check_all_idle_zero("reset");
    tick();
    areset = 1'b0;
    tick();
    @(negedge aclk);
    check_eq("post_rst_arready", 32'(arready), 32'(1));
    check_eq("post_rst_awready", 32'(awready), 32'(1));
    check_eq("post_rst_wready",  32'(wready),  32'(1));
    tick();

    // Basic full write, AW and W together
    axi_write(32'h4, 32'hdeadbeef, 4'hF, 0, 0);
    axi_read(32'h4, 0);
    // AW three cycles ahead of W
    axi_write(32'h8, 32'h12345678, 4'hF, 3, 0);
    axi_read(32'h8, 0);
    // Partial strobes, then an all-zero strobe no-op
    axi_write(32'h4, 32'hAABBCCDD, 4'b0101, 0, 0);
    axi_read(32'h4, 0);
    axi_write(32'h4, 32'h11111111, 4'b0000, 0, 0);
    axi_read(32'h4, 0);
    // Out of range
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0);
    axi_read(32'h40, 0);
    axi_read(32'hFFFFFFFC, 0);
    // Last in-range word, read back through an address with byte-offset bits set
    axi_write(32'h3C, 32'hCAFEF00D, 4'hF, 1, 0);
    axi_read(32'h3F, 0);
    axi_read(32'h7, 0);
    // Whole bank: nothing else disturbed
    for (int i = 0; i < NUM_REGS; i++) axi_read(addr_t'(4 * i), 0);
    // Back-pressure on R and B
    axi_read(32'h8, 5);
    axi_write(32'h10, 32'h0badc0de, 4'hF, 0, 5);
    axi_read(32'h10, 0);

    // Reset with a write in W_RESP and a read in R_DATA
    awaddr  = 32'hC;
    wdata   = 32'h5555aaaa;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    wait_ready(3, "rst_aw_ready");
    awvalid = 1'b0;
    wvalid  = 1'b0;
    araddr  = 32'h4;
    arvalid = 1'b1;
    wait_ready(0, "rst_ar_ready");
    arvalid = 1'b0;
    @(negedge aclk);
    check_eq("rst_pre_rvalid", 32'(rvalid), 32'(1));
    check_eq("rst_pre_bvalid", 32'(bvalid), 32'(1));
    tick();
    areset = 1'b1;
    tick();
    @(negedge aclk);
    check_all_idle_zero("mid_rst");
    tick();
    areset = 1'b0;
    tick();
    @(negedge aclk);
    check_eq("rel_arready", 32'(arready), 32'(1));
    check_eq("rel_awready", 32'(awready), 32'(1));
    check_eq("rel_wready",  32'(wready),  32'(1));
    check_eq("rel_rvalid",  32'(rvalid),  32'(0));
    check_eq("rel_bvalid",  32'(bvalid),  32'(0));
    tick();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    for (int i = 0; i < NUM_REGS; i++) axi_read(addr_t'(4 * i), 0);

    check_eq("rq_drained", 32'(rq.size()), 32'(0));
    check_eq("bq_drained", 32'(bq.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
